// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared Y86-64 icode, status and register constants
package y86_pkg;

    localparam logic [3:0] NOP    = 4'h1;
    localparam logic [3:0] RMMOVQ = 4'h4;
    localparam logic [3:0] MRMOVQ = 4'h5;
    localparam logic [3:0] CALL   = 4'h8;
    localparam logic [3:0] RET    = 4'h9;
    localparam logic [3:0] PUSHQ  = 4'hA;
    localparam logic [3:0] POPQ   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] RNONE = 4'hF;

    function automatic logic is_mem_read(input logic [3:0] icode);
        return (icode == MRMOVQ) || (icode == RET) || (icode == POPQ);
    endfunction

    function automatic logic is_mem_write(input logic [3:0] icode);
        return (icode == RMMOVQ) || (icode == CALL) || (icode == PUSHQ);
    endfunction

    // ret/popq address the stack through valA; everything else uses the ALU result
    function automatic logic addr_from_vala(input logic [3:0] icode);
        return (icode == RET) || (icode == POPQ);
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// rtl/memory_stage_if.sv - execute-to-memory pipeline bus
interface memory_stage_if;
    logic [3:0]  e_icode;
    logic        e_cnd;
    logic [63:0] e_valE;
    logic [63:0] e_valA;
    logic [3:0]  e_dstE;
    logic [3:0]  e_dstM;
    logic [2:0]  e_stat;

    modport master (output e_icode, e_cnd, e_valE, e_valA, e_dstE, e_dstM, e_stat);
    modport slave  (input  e_icode, e_cnd, e_valE, e_valA, e_dstE, e_dstM, e_stat);
endinterface

// File: rtl/data_mem.sv
// rtl/data_mem.sv - 64-bit word data memory with alignment and range checking
module data_mem #(
    parameter int MEM_WORDS = 512
) (
    input  logic        clk,
    input  logic [63:0] addr,
    input  logic        access,
    input  logic        we,
    input  logic [63:0] wdata,
    output logic [63:0] rdata,
    output logic        error
);
    localparam int AW = $clog2(MEM_WORDS);

    logic [63:0]   mem [MEM_WORDS];
    logic [AW-1:0] idx;

    assign idx   = addr[AW+2:3];
    assign error = access && ((addr[2:0] != 3'b000) || (addr >= (64'(MEM_WORDS) << 3)));
    assign rdata = mem[idx];

    // contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end
endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - Y86-64 memory stage with M and W pipeline registers
module memory_stage
    import y86_pkg::*;
#(
    parameter int MEM_WORDS = 512
) (
    input  logic           clk,
    input  logic           rst,
    memory_stage_if.slave  ex,
    input  logic           M_stall,
    input  logic           M_bubble,
    input  logic           W_stall,
    output logic [3:0]     M_icode,
    output logic           M_cnd,
    output logic [63:0]    M_valE,
    output logic [63:0]    M_valA,
    output logic [3:0]     M_dstE,
    output logic [3:0]     M_dstM,
    output logic [2:0]     M_stat,
    output logic [63:0]    m_valM,
    output logic [2:0]     m_stat,
    output logic [3:0]     W_icode,
    output logic [63:0]    W_valE,
    output logic [63:0]    W_valM,
    output logic [3:0]     W_dstE,
    output logic [3:0]     W_dstM,
    output logic [2:0]     W_stat
);
    logic [63:0] mem_addr;
    logic [63:0] mem_rdata;
    logic        mem_read;
    logic        mem_write;
    logic        mem_we;
    logic        dmem_error;

    assign mem_addr  = addr_from_vala(M_icode) ? M_valA : M_valE;
    assign mem_read  = is_mem_read(M_icode);
    assign mem_write = is_mem_write(M_icode);

    // an exception already in W blocks younger stores; rst gates a write caught mid-reset
    assign mem_we = mem_write && !dmem_error && (M_stat == STAT_AOK)
                    && (W_stat == STAT_AOK) && !rst;

    data_mem #(.MEM_WORDS(MEM_WORDS)) u_dmem (
        .clk    (clk),
        .addr   (mem_addr),
        .access (mem_read || mem_write),
        .we     (mem_we),
        .wdata  (M_valA),
        .rdata  (mem_rdata),
        .error  (dmem_error)
    );

    assign m_stat = dmem_error ? STAT_ADR : M_stat;
    assign m_valM = (mem_read && !dmem_error) ? mem_rdata : 64'd0;

    always_ff @(posedge clk) begin
        if (rst || (M_bubble && !M_stall)) begin
            M_icode <= NOP;
            M_cnd   <= 1'b0;
            M_valE  <= 64'd0;
            M_valA  <= 64'd0;
            M_dstE  <= RNONE;
            M_dstM  <= RNONE;
            M_stat  <= STAT_AOK;
        end else if (!M_stall) begin
            M_icode <= ex.e_icode;
            M_cnd   <= ex.e_cnd;
            M_valE  <= ex.e_valE;
            M_valA  <= ex.e_valA;
            M_dstE  <= ex.e_dstE;
            M_dstM  <= ex.e_dstM;
            M_stat  <= ex.e_stat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            W_icode <= NOP;
            W_valE  <= 64'd0;
            W_valM  <= 64'd0;
            W_dstE  <= RNONE;
            W_dstM  <= RNONE;
            W_stat  <= STAT_AOK;
        end else if (!W_stall) begin
            W_icode <= M_icode;
            W_valE  <= M_valE;
            W_valM  <= m_valM;
            W_dstE  <= M_dstE;
            W_dstM  <= M_dstM;
            W_stat  <= m_stat;
        end
    end
endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - directed self-checking bench for memory_stage
module tb_memory_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        M_stall = 1'b0, M_bubble = 1'b0, W_stall = 1'b0;
    logic [3:0]  M_icode, M_dstE, M_dstM, W_icode, W_dstE, W_dstM;
    logic        M_cnd;
    logic [63:0] M_valE, M_valA, m_valM, W_valE, W_valM;
    logic [2:0]  M_stat, m_stat, W_stat;
    int total = 0;
    int bad = 0;

    memory_stage_if eif ();

    memory_stage #(.MEM_WORDS(512)) dut (
        .clk(clk), .rst(rst), .ex(eif.slave),
        .M_stall(M_stall), .M_bubble(M_bubble), .W_stall(W_stall),
        .M_icode(M_icode), .M_cnd(M_cnd), .M_valE(M_valE), .M_valA(M_valA),
        .M_dstE(M_dstE), .M_dstM(M_dstM), .M_stat(M_stat),
        .m_valM(m_valM), .m_stat(m_stat),
        .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
        .W_dstE(W_dstE), .W_dstM(W_dstM), .W_stat(W_stat)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] ic, input logic [63:0] ve, input logic [63:0] va,
                         input logic [3:0] de, input logic [3:0] dm, input logic [2:0] st,
                         input logic cnd);
        eif.e_icode = ic; eif.e_valE = ve; eif.e_valA = va;
        eif.e_dstE = de; eif.e_dstM = dm; eif.e_stat = st; eif.e_cnd = cnd;
    endtask

    task automatic issue(input logic [3:0] ic, input logic [63:0] ve, input logic [63:0] va);
        drive(ic, ve, va, 4'hF, 4'hF, 3'd1, 1'b0);
        step();
    endtask

    task automatic test_reset();
        drive(4'h3, 64'h99, 64'h98, 4'h2, 4'h3, 3'd2, 1'b1);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (M_icode !== 4'h1) begin bad++; $display("FAIL reset_M_icode got=%h exp=1", M_icode); end
        total++; if (M_dstE !== 4'hF || M_dstM !== 4'hF) begin bad++; $display("FAIL reset_M_dst got=%h/%h exp=F/F", M_dstE, M_dstM); end
        total++; if (W_stat !== 3'd1) begin bad++; $display("FAIL reset_W_stat got=%0d exp=1", W_stat); end
        total++; if (W_valM !== 64'd0) begin bad++; $display("FAIL reset_W_valM got=%h exp=0", W_valM); end
    endtask

    task automatic test_store_load();
        issue(4'h4, 64'h10, 64'hDEADBEEF);
        total++; if (m_stat !== 3'd1) begin bad++; $display("FAIL st_m_stat got=%0d exp=1", m_stat); end
        issue(4'h5, 64'h10, 64'h0);
        total++; if (m_valM !== 64'hDEADBEEF) begin bad++; $display("FAIL ld_m_valM got=%h exp=deadbeef", m_valM); end
        total++; if (m_stat !== 3'd1) begin bad++; $display("FAIL ld_m_stat got=%0d exp=1", m_stat); end
        issue(4'h1, 64'h0, 64'h0);
        total++; if (W_valM !== 64'hDEADBEEF) begin bad++; $display("FAIL ld_W_valM got=%h exp=deadbeef", W_valM); end
        total++; if (W_icode !== 4'h5) begin bad++; $display("FAIL ld_W_icode got=%h exp=5", W_icode); end
    endtask

    task automatic test_push_pop();
        issue(4'hA, 64'h1F8, 64'h55);
        issue(4'hB, 64'h200, 64'h1F8);
        total++; if (m_valM !== 64'h55) begin bad++; $display("FAIL pop_m_valM got=%h exp=55", m_valM); end
    endtask

    task automatic test_call_ret();
        issue(4'h8, 64'h40, 64'h1234);
        issue(4'h9, 64'h48, 64'h40);
        total++; if (m_valM !== 64'h1234) begin bad++; $display("FAIL ret_m_valM got=%h exp=1234", m_valM); end
    endtask

    task automatic test_addr_error();
        issue(4'h4, 64'h0, 64'h0);
        issue(4'h1, 64'h0, 64'h0);
        issue(4'h5, 64'h13, 64'h0);
        total++; if (m_stat !== 3'd3) begin bad++; $display("FAIL misalign_m_stat got=%0d exp=3", m_stat); end
        total++; if (m_valM !== 64'd0) begin bad++; $display("FAIL misalign_m_valM got=%h exp=0", m_valM); end
        issue(4'h1, 64'h0, 64'h0);
        issue(4'h4, 64'h1000, 64'h99);
        total++; if (m_stat !== 3'd3) begin bad++; $display("FAIL range_m_stat got=%0d exp=3", m_stat); end
        issue(4'h5, 64'hFF8, 64'h0);
        total++; if (m_stat !== 3'd1) begin bad++; $display("FAIL lastword_m_stat got=%0d exp=1", m_stat); end
        issue(4'h5, 64'h0, 64'h0);
        total++; if (m_valM !== 64'd0) begin bad++; $display("FAIL range_nowrite got=%h exp=0", m_valM); end
    endtask

    task automatic test_store_block();
        issue(4'h4, 64'h20, 64'h0);
        issue(4'h5, 64'h13, 64'h0);
        issue(4'hA, 64'h20, 64'h77);
        total++; if (W_stat !== 3'd3) begin bad++; $display("FAIL blk_W_stat got=%0d exp=3", W_stat); end
        total++; if (m_stat !== 3'd1) begin bad++; $display("FAIL blk_m_stat got=%0d exp=1", m_stat); end
        issue(4'h5, 64'h20, 64'h0);
        total++; if (m_valM !== 64'd0) begin bad++; $display("FAIL blk_nowrite got=%h exp=0", m_valM); end
    endtask

    task automatic test_reset_midop();
        issue(4'h4, 64'h30, 64'h0);
        issue(4'h4, 64'h30, 64'hAA);
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (M_icode !== 4'h1 || W_icode !== 4'h1) begin bad++; $display("FAIL rstmid_icode got=%h/%h exp=1/1", M_icode, W_icode); end
        issue(4'h5, 64'h30, 64'h0);
        total++; if (m_valM !== 64'd0) begin bad++; $display("FAIL rstmid_nowrite got=%h exp=0", m_valM); end
    endtask

    task automatic test_pipeline_ctrl();
        drive(4'h3, 64'h123, 64'h0, 4'h2, 4'hF, 3'd1, 1'b1);
        step();
        M_stall = 1'b1;
        drive(4'h6, 64'hAAA, 64'hBBB, 4'h7, 4'h8, 3'd1, 1'b0);
        step();
        drive(4'h2, 64'hCCC, 64'hDDD, 4'h9, 4'hA, 3'd2, 1'b0);
        step();
        total++; if (M_icode !== 4'h3 || M_valE !== 64'h123 || M_dstE !== 4'h2 || M_cnd !== 1'b1)
            begin bad++; $display("FAIL mstall_hold got=%h/%h/%h/%b exp=3/123/2/1", M_icode, M_valE, M_dstE, M_cnd); end
        M_stall = 1'b0; M_bubble = 1'b1;
        step();
        total++; if (M_icode !== 4'h1 || M_dstE !== 4'hF || M_valE !== 64'd0 || M_cnd !== 1'b0)
            begin bad++; $display("FAIL mbubble got=%h/%h/%h/%b exp=1/F/0/0", M_icode, M_dstE, M_valE, M_cnd); end
        M_bubble = 1'b0;
        drive(4'h6, 64'h456, 64'h0, 4'h3, 4'hF, 3'd1, 1'b0);
        step();
        M_stall = 1'b1; M_bubble = 1'b1;
        drive(4'h2, 64'h789, 64'h0, 4'h4, 4'hF, 3'd1, 1'b0);
        step();
        total++; if (M_icode !== 4'h6 || M_valE !== 64'h456)
            begin bad++; $display("FAIL stall_over_bubble got=%h/%h exp=6/456", M_icode, M_valE); end
        M_stall = 1'b0; M_bubble = 1'b0; W_stall = 1'b1;
        step();
        step();
        total++; if (W_icode !== 4'h6 || W_valE !== 64'h456 || W_dstE !== 4'h3)
            begin bad++; $display("FAIL wstall_hold got=%h/%h/%h exp=6/456/3", W_icode, W_valE, W_dstE); end
        W_stall = 1'b0;
        step();
        total++; if (W_icode !== 4'h2 || W_valE !== 64'h789)
            begin bad++; $display("FAIL wstall_release got=%h/%h exp=2/789", W_icode, W_valE); end
    endtask

    initial begin
        drive(4'h1, 64'h0, 64'h0, 4'hF, 4'hF, 3'd1, 1'b0);
        #1;
        test_reset();
        test_store_load();
        test_push_pop();
        test_call_ret();
        test_addr_error();
        test_store_block();
        test_reset_midop();
        test_pipeline_ctrl();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
